// File: rtl/sys_bus_pkg.sv
// Shared types for system bus initiators:
// FSM states, bus widths and command/response bundles.
package sys_bus_pkg;

    localparam int SYS_AW = 32;
    localparam int SYS_DW = 32;
    localparam int SYS_SW = 4;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } sys_bus_state_t;

    typedef struct packed {
        logic              we;
        logic [SYS_AW-1:0] addr;
        logic [SYS_DW-1:0] wdata;
        logic [SYS_SW-1:0] sel;
    } sys_cmd_t;

    typedef struct packed {
        logic [SYS_DW-1:0] rdata;
        logic              err;
        logic              timeout;
    } sys_rsp_t;

endpackage

// File: rtl/sys_bus_initiator.sv
// Single-outstanding system bus initiator with a
// cycle-count watchdog and saturating statistics.
module sys_bus_initiator
    import sys_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [SYS_AW-1:0] cmd_addr_i,
    input  logic [SYS_DW-1:0] cmd_wdata_i,
    input  logic [SYS_SW-1:0] cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [SYS_DW-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic [SYS_AW-1:0] sys_addr_o,
    output logic [SYS_DW-1:0] sys_wdata_o,
    output logic [SYS_SW-1:0] sys_sel_o,
    output logic              sys_wen_o,
    output logic              sys_ren_o,
    input  logic [SYS_DW-1:0] sys_rdata_i,
    input  logic              sys_err_i,
    input  logic              sys_ack_i,
    output logic              busy_o,
    output logic [CNTW-1:0]   txn_cnt_o,
    output logic [CNTW-1:0]   tmo_cnt_o
);

    // Watchdog reads 0 in the first WAIT cycle, so the
    // last permitted WAIT cycle sees TIMEOUT-1.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    sys_bus_state_t state_q, state_d;
    sys_cmd_t       cmd_q;
    sys_rsp_t       rsp_q;
    logic [15:0]    wdog_q;
    logic           wen_q, ren_q, rsp_valid_q;
    logic [CNTW-1:0] txn_q, tmo_q;

    logic accept, ack_hit, tmo_hit, rsp_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        ack_hit  = 1'b0;
        tmo_hit  = 1'b0;
        rsp_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (sys_ack_i) begin
                    ack_hit = 1'b1;
                    state_d = RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q  <= '0;
            wen_q  <= 1'b0;
            ren_q  <= 1'b0;
            wdog_q <= '0;
        end else begin
            wen_q <= accept & cmd_we_i;
            ren_q <= accept & ~cmd_we_i;
            if (accept) begin
                cmd_q.we    <= cmd_we_i;
                cmd_q.addr  <= cmd_addr_i;
                cmd_q.wdata <= cmd_wdata_i;
                cmd_q.sel   <= cmd_sel_i;
            end
            if (state_q == STROBE) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            txn_q       <= '0;
            tmo_q       <= '0;
        end else begin
            if (ack_hit) begin
                rsp_q.rdata   <= cmd_q.we ? '0 : sys_rdata_i;
                rsp_q.err     <= sys_err_i;
                rsp_q.timeout <= 1'b0;
            end else if (tmo_hit) begin
                rsp_q.rdata   <= '0;
                rsp_q.err     <= 1'b1;
                rsp_q.timeout <= 1'b1;
            end
            if (ack_hit || tmo_hit) begin
                rsp_valid_q <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
            if (tmo_hit && !(&tmo_q)) begin
                tmo_q <= tmo_q + CNTW'(1);
            end
            if (rsp_done && !(&txn_q)) begin
                txn_q <= txn_q + CNTW'(1);
            end
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;
    assign sys_addr_o    = cmd_q.addr;
    assign sys_wdata_o   = cmd_q.wdata;
    assign sys_sel_o     = cmd_q.sel;
    assign sys_wen_o     = wen_q;
    assign sys_ren_o     = ren_q;
    assign txn_cnt_o     = txn_q;
    assign tmo_cnt_o     = tmo_q;

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Randomized scoreboard bench for sys_bus_initiator with
// a memory-backed responder and a transaction-level model.
module tb_sys_bus_initiator;

    localparam int TMO  = 8;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam logic [31:0] STALE_DATA = 32'hBAD0_0000;
    localparam logic [31:0] LATE_DATA  = 32'h1A7E_0000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [31:0]   cmd_addr_i = '0;
    logic [31:0]   cmd_wdata_i = '0;
    logic [3:0]    cmd_sel_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic [31:0]   sys_addr_o;
    logic [31:0]   sys_wdata_o;
    logic [3:0]    sys_sel_o;
    logic          sys_wen_o;
    logic          sys_ren_o;
    logic [31:0]   sys_rdata_i = '0;
    logic          sys_err_i = 1'b0;
    logic          sys_ack_i = 1'b0;
    logic          busy_o;
    logic [CW-1:0] txn_cnt_o;
    logic [CW-1:0] tmo_cnt_o;

    sys_bus_initiator #(.TIMEOUT(TMO), .CNTW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o),
        .sys_sel_o(sys_sel_o), .sys_wen_o(sys_wen_o),
        .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i),
        .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i),
        .busy_o(busy_o), .txn_cnt_o(txn_cnt_o),
        .tmo_cnt_o(tmo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // d: ack delay in cycles after the strobe, 0 = never acks
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          d;
        logic        err;
        logic        stale;
        int          acc;
    } cfg_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
        int          acc;
    } exp_t;

    cfg_t        cfg_q[$];
    exp_t        exp_q[$];
    logic [31:0] mmem[64];
    logic [31:0] rmem[64];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = -10;
    int mtxn = 0;
    int mtmo = 0;
    int n_str = 0;
    int n_acc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Transaction-level prediction: ack within TMO cycles wins,
    // otherwise the access times out. Word 0 is a read-only ID.
    function automatic exp_t predict(input cfg_t c);
        exp_t e;
        int idx = int'(c.addr[7:2]);
        e.acc = c.acc;
        if (c.d >= 1 && c.d <= TMO) begin
            e.lat = c.d + 2;
            e.err = c.err;
            e.tmo = 1'b0;
            if (c.we) begin
                e.rdata = '0;
                if (!c.err && idx != 0)
                    mmem[idx] = merge(mmem[idx], c.wdata, c.sel);
            end else begin
                e.rdata = c.err ? ERR_DATA : mmem[idx];
            end
        end else begin
            e.lat = TMO + 2;
            e.rdata = '0;
            e.err = 1'b1;
            e.tmo = 1'b1;
        end
        return e;
    endfunction

    function automatic cfg_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] s,
                                input int d, input logic err,
                                input logic stale);
        cfg_t c;
        c.we = we; c.addr = a; c.wdata = wd; c.sel = s;
        c.d = d; c.err = err; c.stale = stale; c.acc = 0;
        return c;
    endfunction

    function automatic cfg_t rnd_cfg();
        cfg_t c;
        int r = int'($urandom_range(0, 15));
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        c.wdata = $urandom;
        c.sel   = 4'($urandom_range(1, 15));
        c.err   = ($urandom_range(0, 7) == 0);
        c.stale = ($urandom_range(0, 5) == 0);
        c.acc   = 0;
        if (r < 9)       c.d = int'($urandom_range(1, 3));
        else if (r == 9) c.d = int'($urandom_range(4, TMO - 1));
        else if (r < 12) c.d = TMO;
        else if (r == 12) c.d = 0;
        else             c.d = int'($urandom_range(TMO + 1, TMO + 3));
        return c;
    endfunction

    task automatic issue(input cfg_t c);
        int n = 0;
        logic waited = 1'b0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = c.we;
        cmd_addr_i  = c.addr;
        cmd_wdata_i = c.wdata;
        cmd_sel_i   = c.sel;
        while (!cmd_ready_o) begin
            @(negedge clk_i);
            waited = 1'b1;
            n++;
            if (n > 200) begin
                chk("cmd_accept_timeout", 32'(cmd_ready_o), 32'd1);
                cmd_valid_i = 1'b0;
                return;
            end
        end
        c.acc = cyc;
        if (waited) chk("accept_after_hs", c.acc, hs_cyc + 1);
        n_acc++;
        cfg_q.push_back(c);
        exp_q.push_back(predict(c));
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
    endtask

    // Responder: acks d cycles after the strobe, optionally
    // with a stale ack in the strobe cycle itself.
    cfg_t cur;
    int   rem = 0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            sys_ack_i = 1'b0;
            sys_err_i = 1'b0;
            sys_rdata_i = '0;
            rem = 0;
        end else begin
            sys_ack_i = 1'b0;
            sys_err_i = 1'b0;
            sys_rdata_i = '0;
            if (rem != 0) begin
                rem--;
                if (rem == 0) begin
                    sys_ack_i = 1'b1;
                    if (cur.d > TMO) begin
                        sys_rdata_i = LATE_DATA;
                    end else begin
                        chk("addr_held", sys_addr_o, cur.addr);
                        sys_err_i = cur.err;
                        if (cur.err) begin
                            sys_rdata_i = ERR_DATA;
                        end else if (cur.we) begin
                            if (cur.addr[7:2] != 6'd0)
                                rmem[cur.addr[7:2]] = merge(
                                    rmem[cur.addr[7:2]],
                                    sys_wdata_o, sys_sel_o);
                        end else begin
                            sys_rdata_i = rmem[cur.addr[7:2]];
                        end
                    end
                end
            end
            if (sys_ren_o || sys_wen_o) begin
                n_str++;
                chk("strobe_count", n_str, n_acc);
                if (cfg_q.size() == 0) begin
                    chk("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = cfg_q.pop_front();
                    chk("strobe_cycle", cyc, cur.acc + 1);
                    chk("strobe_kind", {sys_wen_o, sys_ren_o},
                        {cur.we, ~cur.we});
                    chk("bus_addr", sys_addr_o, cur.addr);
                    chk("bus_sel", 32'(sys_sel_o), 32'(cur.sel));
                    if (cur.we) chk("bus_wdata", sys_wdata_o, cur.wdata);
                    rem = cur.d;
                    if (cur.stale) begin
                        sys_ack_i = 1'b1;
                        sys_err_i = 1'b1;
                        sys_rdata_i = STALE_DATA;
                    end
                end
            end
        end
    end

    // Monitor: random backpressure, compares while the response
    // is presented and pops on the handshake.
    logic seen = 1'b0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            rsp_ready_i = ($urandom_range(0, 9) < 7);
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        chk("rsp_latency", cyc - e.acc, e.lat);
                    end
                    chk("rdy_in_resp", 32'(cmd_ready_o), 32'd0);
                    chk("rsp_rdata", rsp_rdata_o, e.rdata);
                    chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.tmo));
                    if (rsp_ready_i) begin
                        if (e.tmo && mtmo < CMAX) mtmo++;
                        chk("tmo_cnt", 32'(tmo_cnt_o), mtmo);
                        chk("txn_cnt", 32'(txn_cnt_o), mtxn);
                        if (mtxn < CMAX) mtxn++;
                        hs_cyc = cyc;
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mmem[i] = {16'hC0DE, 10'd0, 6'(i)};
            rmem[i] = mmem[i];
        end
        mmem[0] = 32'h0000_0001;
        rmem[0] = 32'h0000_0001;

        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_flags", {rsp_err_o, rsp_timeout_o}, 32'd0);
        chk("rst_sys_addr", sys_addr_o, 32'd0);
        chk("rst_sys_wdata", sys_wdata_o, 32'd0);
        chk("rst_sys_misc", {sys_sel_o, sys_wen_o, sys_ren_o}, 32'd0);
        chk("rst_cnts", {tmo_cnt_o, txn_cnt_o}, 32'd0);
        rst_i = 1'b0;

        issue(mk(1'b0, 32'h0, 32'h0, 4'hF, 1, 1'b0, 1'b0));
        issue(mk(1'b1, 32'h30, 32'hA5, 4'hF, 1, 1'b0, 1'b0));
        issue(mk(1'b0, 32'h30, 32'h0, 4'hF, 2, 1'b0, 1'b0));
        issue(mk(1'b0, 32'h34, 32'h0, 4'hF, TMO + 2, 1'b0, 1'b0));
        issue(mk(1'b0, 32'h30, 32'h0, 4'hF, 1, 1'b0, 1'b0));
        issue(mk(1'b0, 32'h38, 32'h0, 4'hF, 1, 1'b1, 1'b0));
        issue(mk(1'b0, 32'h3C, 32'h0, 4'hF, 3, 1'b0, 1'b1));
        issue(mk(1'b0, 32'h40, 32'h0, 4'hF, TMO, 1'b0, 1'b0));

        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            issue(rnd_cfg());
        end
        drain();

        issue(mk(1'b0, 32'h44, 32'h0, 4'hF, 0, 1'b0, 1'b0));
        @(negedge clk_i);
        @(negedge clk_i);
        chk("busy_in_wait", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("arst_ren", 32'(sys_ren_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("arst_cnts", {tmo_cnt_o, txn_cnt_o}, 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        exp_q.delete();
        cfg_q.delete();
        mtxn = 0;
        mtmo = 0;
        seen = 1'b0;
        n_str = 0;
        n_acc = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (TMO + 6) @(negedge clk_i);
        chk("post_rst_idle", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
